sys_debug_sequencer: RTL and testbench
======================================

Name: sys_debug_sequencer

Overview:
- Synthesizable command engine that drives the CPU system's debug/test interface: memory load/read, register load/read, CPU reset-to-PC, and run-until-PC or run-N-instructions.
- Replaces hand-written bench tasks with a hardware sequencer, so a UART or host bridge (or a bench) can issue commands.
- Sits between the command source and the SystemTest-style debug port.
- Generalised in data/address width, access latency and run limits; adds run-N mode, a cycle timeout and status reporting.

Parameters:
- DATA_W, 16, data width of memory/register words and PC.
- ADDR_W, 16, memory address width.
- REG_AW, 4, register-file address width.
- ACC_LAT, 2, cycles an access is held before rdata is sampled (≥1).
- CNT_W, 16, width of the instruction counter and N operand.
- TMO_W, 24, width of the run-cycle timeout counter.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_op  in  3  0=WMEM 1=RMEM 2=WREG 3=RREG 4=RUN_UNTIL 5=RUN_N; others invalid.
- cmd_addr  in  ADDR_W  memory address / register address (low REG_AW bits) / start PC.
- cmd_data  in  DATA_W  write data / stop PC / N (low CNT_W bits).
- cmd_tmo  in  TMO_W  run timeout in cycles; 0 = no timeout.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed.
- rsp_status  out  2  0=OK 1=TIMEOUT 2=BAD_CMD 3=VERIFY_FAIL.
- rsp_data  out  DATA_W  read data (RMEM/RREG), final PC (RUN_*), readback (WMEM/WREG).
- rsp_count  out  CNT_W  instructions executed (RUN_*), else 0.
- dbg_test  out  1  CPU run enable.
- dbg_cpu_reset  out  1  CPU reset (active high).
- dbg_resetpc  out  DATA_W  CPU reset PC.
- dbg_memop / dbg_memwrite  out  1 / 1  memory-port select and write strobe.
- dbg_memaddr / dbg_memwdata  out  ADDR_W / DATA_W  memory address and write data.
- dbg_regop / dbg_regwrite  out  1 / 1  register-port select and write strobe.
- dbg_regaddr / dbg_regwdata  out  REG_AW / DATA_W  register address and write data.
- dbg_md / dbg_rd  in  DATA_W / DATA_W  memory / register read data.
- dbg_pc  in  DATA_W  CPU PC.
- dbg_fetch  in  1  CPU is in fetch state (state==1).

Behaviour:
- Reset (reset==0 at posedge): state IDLE; all dbg_* outputs 0; rsp_valid=0; rsp_* =0; cmd_ready=1. Reset mid-run or mid-access aborts immediately and produces no response.
- cmd_ready=1 only in IDLE. A command is accepted on a cycle with cmd_valid&cmd_ready. Operands are latched on acceptance.
- States: IDLE, ACCESS, RST0, RST1, RUN, RESP.
- Invalid op: go directly to RESP with BAD_CMD.
- ACCESS (WMEM/RMEM/WREG/RREG): hold the op select, address, write data and write strobe for ACC_LAT cycles. On the last cycle sample dbg_md or dbg_rd into rsp_data, then drop all strobes.
  - Write commands report VERIFY_FAIL if the sampled data ≠ written data, else OK.
- RUN_*:
  - RST0: dbg_cpu_reset=1, dbg_resetpc=start PC, dbg_test=0, one cycle.
  - RST1: reset released, one cycle.
  - RUN: dbg_test=1. Instruction counter starts at 0 and increments on each rising edge of dbg_fetch. The timeout counter increments every RUN cycle.
  - RUN_UNTIL ends on the first cycle where dbg_fetch=1, count≥1 and dbg_pc==stop PC+1 (PC is post-increment during fetch).
  - RUN_N ends when the count reaches N. N=0 ends immediately with count 0.
  - Timeout ends the run when the cycle count reaches cmd_tmo≠0, with status TIMEOUT.
  - If timeout and completion occur in the same cycle, completion wins (OK).
  - On exit: dbg_test=0 the next cycle, rsp_data=dbg_pc, rsp_count=count. The counter saturates at all-ones rather than wrapping.
- RESP: rsp_valid=1 with stable data until rsp_ready=1, then IDLE.
  - cmd_ready returns to 1 the cycle after the handshake. A new command is never accepted while rsp_valid=1.
- Latency from acceptance to rsp_valid: ACCESS = ACC_LAT+1 cycles; BAD_CMD = 1 cycle.
- dbg_memop and dbg_regop are never asserted together. dbg_test is never asserted outside RUN.

Test Plan:
- WMEM addr 7 data 0xAE07, then RMEM 7 → OK, rsp_data=0xAE07; dbg_memwrite high for exactly ACC_LAT cycles.
- WREG 0 data 2310, then RREG 0 → 0x0906. Force dbg_rd mismatch on a write → VERIFY_FAIL.
- Load the relPrime program, WREG 0 = 120, RUN_UNTIL start 0 stop 3, then RREG 10 → 7. Repeat with inputs 840→11, 1024→3, 30030→17; rsp_data=4.
- RUN_N start 0 N=5 → rsp_count=5, dbg_test falls the cycle after the fifth fetch; N=0 → count 0.
- RUN_UNTIL with an unreachable stop PC and cmd_tmo=1000 → TIMEOUT after 1000 RUN cycles, dbg_test=0.
- cmd_op=7 → BAD_CMD. Hold rsp_ready=0 for 5 cycles → response held stable with cmd_ready=0. Assert reset mid-RUN → all outputs 0, no response.

Source files
------------

// File: rtl/sys_debug_sequencer.sv
// sys_debug_sequencer: command engine driving the CPU debug/test port (memory/register access, reset-to-PC, run modes)
module sys_debug_sequencer #(
   parameter int DATA_W  = 16,
   parameter int ADDR_W  = 16,
   parameter int REG_AW  = 4,
   parameter int ACC_LAT = 2,
   parameter int CNT_W   = 16,
   parameter int TMO_W   = 24
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [2:0]        cmd_op,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_data,
   input  logic [TMO_W-1:0]  cmd_tmo,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [1:0]        rsp_status,
   output logic [DATA_W-1:0] rsp_data,
   output logic [CNT_W-1:0]  rsp_count,
   output logic              dbg_test,
   output logic              dbg_cpu_reset,
   output logic [DATA_W-1:0] dbg_resetpc,
   output logic              dbg_memop,
   output logic              dbg_memwrite,
   output logic [ADDR_W-1:0] dbg_memaddr,
   output logic [DATA_W-1:0] dbg_memwdata,
   output logic              dbg_regop,
   output logic              dbg_regwrite,
   output logic [REG_AW-1:0] dbg_regaddr,
   output logic [DATA_W-1:0] dbg_regwdata,
   input  logic [DATA_W-1:0] dbg_md,
   input  logic [DATA_W-1:0] dbg_rd,
   input  logic [DATA_W-1:0] dbg_pc,
   input  logic              dbg_fetch
);
   localparam logic [2:0] OP_WMEM = 3'd0, OP_RMEM = 3'd1, OP_WREG = 3'd2, OP_RREG = 3'd3, OP_RUN_N = 3'd5;
   localparam logic [1:0] ST_OK = 2'd0, ST_TMO = 2'd1, ST_BAD = 2'd2, ST_VFY = 2'd3;
   localparam int AC_W = (ACC_LAT > 1) ? $clog2(ACC_LAT) : 1;
   typedef enum logic [2:0] {IDLE, ACCESS, RST0, RST1, RUN, RESP} state_t;
   state_t            state;
   logic [2:0]        op_q;
   logic [DATA_W-1:0] data_q;
   logic [TMO_W-1:0]  tmo_lim;
   logic [TMO_W-1:0]  tmo;
   logic [TMO_W-1:0]  tmo_nxt;
   logic [CNT_W-1:0]  cnt;
   logic [CNT_W-1:0]  cnt_nxt;
   logic [CNT_W-1:0]  n_val;
   logic [AC_W-1:0]   acc;
   logic [DATA_W-1:0] rd;
   logic              fetch_q;
   logic              rise;
   logic              run_done;
   logic              run_tmo;
   logic              is_wr;
   // run-exit conditions and access readback selection
   always_comb begin
      rise     = dbg_fetch & ~fetch_q;
      cnt_nxt  = (rise && !(&cnt)) ? cnt + CNT_W'(1) : cnt;
      tmo_nxt  = tmo + TMO_W'(1);
      n_val    = data_q[CNT_W-1:0];
      run_done = (op_q == OP_RUN_N) ? (n_val == '0 || cnt_nxt == n_val)
                                    : (dbg_fetch && cnt_nxt != '0 && dbg_pc == data_q + DATA_W'(1));
      run_tmo  = tmo_lim != '0 && tmo_nxt == tmo_lim;
      rd       = (op_q == OP_WMEM || op_q == OP_RMEM) ? dbg_md : dbg_rd;
      is_wr    = op_q == OP_WMEM || op_q == OP_WREG;
   end
   // sequencer state machine with registered debug-port and response outputs
   always_ff @(posedge clk) begin
      if (!reset) begin
         state         <= IDLE;
         cmd_ready     <= 1'b1;
         rsp_valid     <= 1'b0;
         rsp_status    <= '0;
         rsp_data      <= '0;
         rsp_count     <= '0;
         dbg_test      <= 1'b0;
         dbg_cpu_reset <= 1'b0;
         dbg_resetpc   <= '0;
         dbg_memop     <= 1'b0;
         dbg_memwrite  <= 1'b0;
         dbg_memaddr   <= '0;
         dbg_memwdata  <= '0;
         dbg_regop     <= 1'b0;
         dbg_regwrite  <= 1'b0;
         dbg_regaddr   <= '0;
         dbg_regwdata  <= '0;
         op_q          <= '0;
         data_q        <= '0;
         tmo_lim       <= '0;
         tmo           <= '0;
         cnt           <= '0;
         acc           <= '0;
         fetch_q       <= 1'b0;
      end else begin
         case (state)
            IDLE: if (cmd_valid) begin
               cmd_ready <= 1'b0;
               op_q      <= cmd_op;
               data_q    <= cmd_data;
               tmo_lim   <= cmd_tmo;
               tmo       <= '0;
               cnt       <= '0;
               acc       <= '0;
               fetch_q   <= 1'b0;
               if (cmd_op <= OP_RREG) begin
                  state        <= ACCESS;
                  dbg_memop    <= cmd_op == OP_WMEM || cmd_op == OP_RMEM;
                  dbg_memwrite <= cmd_op == OP_WMEM;
                  dbg_regop    <= cmd_op == OP_WREG || cmd_op == OP_RREG;
                  dbg_regwrite <= cmd_op == OP_WREG;
                  dbg_memaddr  <= cmd_addr;
                  dbg_memwdata <= cmd_data;
                  dbg_regaddr  <= cmd_addr[REG_AW-1:0];
                  dbg_regwdata <= cmd_data;
               end else if (cmd_op <= OP_RUN_N) begin
                  state         <= RST0;
                  dbg_cpu_reset <= 1'b1;
                  dbg_resetpc   <= DATA_W'(cmd_addr);
               end else begin
                  state      <= RESP;
                  rsp_valid  <= 1'b1;
                  rsp_status <= ST_BAD;
                  rsp_data   <= '0;
                  rsp_count  <= '0;
               end
            end
            ACCESS: if (acc == AC_W'(ACC_LAT - 1)) begin
               state        <= RESP;
               dbg_memop    <= 1'b0;
               dbg_memwrite <= 1'b0;
               dbg_regop    <= 1'b0;
               dbg_regwrite <= 1'b0;
               rsp_valid    <= 1'b1;
               rsp_data     <= rd;
               rsp_count    <= '0;
               rsp_status   <= (is_wr && rd != data_q) ? ST_VFY : ST_OK;
            end else begin
               acc <= acc + AC_W'(1);
            end
            RST0: begin
               dbg_cpu_reset <= 1'b0;
               state         <= RST1;
            end
            RST1: begin
               dbg_test <= 1'b1;
               state    <= RUN;
            end
            RUN: begin
               fetch_q <= dbg_fetch;
               cnt     <= cnt_nxt;
               tmo     <= tmo_nxt;
               if (run_done || run_tmo) begin
                  state      <= RESP;
                  dbg_test   <= 1'b0;
                  rsp_valid  <= 1'b1;
                  rsp_status <= run_done ? ST_OK : ST_TMO;
                  rsp_data   <= dbg_pc;
                  rsp_count  <= (op_q == OP_RUN_N && n_val == '0) ? '0 : cnt_nxt;
               end
            end
            RESP: if (rsp_ready) begin
               rsp_valid <= 1'b0;
               cmd_ready <= 1'b1;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_sys_debug_sequencer.sv
// tb_sys_debug_sequencer: randomized self-checking bench with memory, register file and CPU stand-in models
module tb_sys_debug_sequencer;
   localparam int DW = 16, AW = 16, RW = 4, AL = 2, CW = 6, TW = 24;
   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic [2:0]    cmd_op = '0;
   logic [AW-1:0] cmd_addr = '0;
   logic [DW-1:0] cmd_data = '0;
   logic [TW-1:0] cmd_tmo = '0;
   logic          rsp_valid;
   logic          rsp_ready = 1'b0;
   logic [1:0]    rsp_status;
   logic [DW-1:0] rsp_data;
   logic [CW-1:0] rsp_count;
   logic          dbg_test, dbg_cpu_reset, dbg_memop, dbg_memwrite, dbg_regop, dbg_regwrite;
   logic [DW-1:0] dbg_resetpc, dbg_memwdata, dbg_regwdata, dbg_md, dbg_rd, dbg_pc;
   logic [AW-1:0] dbg_memaddr;
   logic [RW-1:0] dbg_regaddr;
   logic          dbg_fetch;
   logic [DW-1:0] mem [0:65535];
   logic [DW-1:0] rf [0:15];
   logic [DW-1:0] md_err = '0;
   logic [DW-1:0] rd_err = '0;
   logic [DW-1:0] cpu_pc = '0;
   logic          cpu_st = 1'b0;
   int            cpu_g = 0;
   int            gap = 0;
   int            checks = 0, errors = 0;
   int            lat, mw_cnt, tst_cnt, ovl;
   logic [1:0]    r_status;
   logic [DW-1:0] r_data;
   logic [CW-1:0] r_count;
   logic [DW-1:0] ref_mem [int];
   logic [DW-1:0] ref_rf [int];

   sys_debug_sequencer #(.DATA_W(DW), .ADDR_W(AW), .REG_AW(RW), .ACC_LAT(AL), .CNT_W(CW), .TMO_W(TW)) dut (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_tmo(cmd_tmo), .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready), .rsp_status(rsp_status), .rsp_data(rsp_data), .rsp_count(rsp_count),
      .dbg_test(dbg_test), .dbg_cpu_reset(dbg_cpu_reset), .dbg_resetpc(dbg_resetpc),
      .dbg_memop(dbg_memop), .dbg_memwrite(dbg_memwrite), .dbg_memaddr(dbg_memaddr),
      .dbg_memwdata(dbg_memwdata), .dbg_regop(dbg_regop), .dbg_regwrite(dbg_regwrite),
      .dbg_regaddr(dbg_regaddr), .dbg_regwdata(dbg_regwdata), .dbg_md(dbg_md), .dbg_rd(dbg_rd),
      .dbg_pc(dbg_pc), .dbg_fetch(dbg_fetch));

   always #5 clk = ~clk;

   assign dbg_md    = mem[dbg_memaddr] ^ md_err;
   assign dbg_rd    = rf[dbg_regaddr] ^ rd_err;
   assign dbg_fetch = cpu_st;
   assign dbg_pc    = cpu_pc;

   // memory, register file and a CPU that fetches sequentially every gap+2 cycles
   always @(posedge clk) begin
      if (dbg_memop && dbg_memwrite) mem[dbg_memaddr] <= dbg_memwdata;
      if (dbg_regop && dbg_regwrite) rf[dbg_regaddr] <= dbg_regwdata;
      if (dbg_cpu_reset) begin
         cpu_pc <= dbg_resetpc;
         cpu_st <= 1'b0;
         cpu_g  <= 0;
      end else if (dbg_test) begin
         if (cpu_st) begin
            cpu_st <= 1'b0;
            cpu_g  <= 0;
         end else if (cpu_g == gap) begin
            cpu_st <= 1'b1;
            cpu_pc <= cpu_pc + 16'd1;
         end else cpu_g <= cpu_g + 1;
      end
   end

   task automatic issue(input logic [2:0] op, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [TW-1:0] t);
      int n;
      n = 0;
      while (cmd_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
      cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_data = d; cmd_tmo = t;
      @(negedge clk);
      cmd_valid = 1'b0;
      lat = 1; mw_cnt = 0; tst_cnt = 0; ovl = 0;
      while (rsp_valid !== 1'b1 && lat < 5000) begin
         if (dbg_memwrite) mw_cnt++;
         if (dbg_test) tst_cnt++;
         if (dbg_memop && dbg_regop) ovl++;
         @(negedge clk);
         lat++;
      end
      checks++;
      if (rsp_valid !== 1'b1) begin errors++; $display("FAIL rsp_timeout op=%0d rsp_valid=%b required 1", op, rsp_valid); end
      r_status = rsp_status; r_data = rsp_data; r_count = rsp_count;
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
   endtask

   task automatic run_ref(input bit is_n, input int start, input int sd, input int tmo, input int p,
                          output int st, output int data, output int cnt, output int cyc);
      int fin, fc, k;
      if (is_n) begin fc = sd % 64; fin = (fc == 0) ? 1 : fc * p; end
      else if (sd >= start) begin fc = sd - start + 1; fin = fc * p; end
      else begin fc = 0; fin = 32'h7fffffff; end
      if (tmo != 0 && tmo < fin) begin st = 1; cyc = tmo; k = tmo / p; end
      else begin st = 0; cyc = fin; k = fc; end
      cnt  = (k > 63) ? 63 : k;
      data = (start + k) % 65536;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({dbg_test, dbg_cpu_reset, dbg_resetpc, dbg_memop, dbg_memwrite, dbg_memaddr, dbg_memwdata, dbg_regop,
           dbg_regwrite, dbg_regaddr, dbg_regwdata, rsp_valid, rsp_status, rsp_data, rsp_count} !== '0 || cmd_ready !== 1'b1) begin
         errors++; $display("FAIL reset_state outputs not all zero or cmd_ready=%b required 1", cmd_ready);
      end
      reset = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_mem();
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      issue(3'd0, 16'd7, 16'hAE07, '0);
      checks++;
      if (r_status !== 2'd0 || r_data !== 16'hAE07) begin errors++; $display("FAIL wmem7 status=%0d data=%h required 0/ae07", r_status, r_data); end
      checks++;
      if (mw_cnt != AL || lat != AL + 1) begin errors++; $display("FAIL wmem_timing memwrite_cycles=%0d latency=%0d required %0d/%0d", mw_cnt, lat, AL, AL + 1); end
      checks++;
      if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL after_handshake cmd_ready=%b rsp_valid=%b required 1/0", cmd_ready, rsp_valid); end
      ref_mem[7] = 16'hAE07;
      issue(3'd1, 16'd7, 16'h0000, '0);
      checks++;
      if (r_status !== 2'd0 || r_data !== 16'hAE07 || mw_cnt != 0) begin errors++; $display("FAIL rmem7 status=%0d data=%h memwrites=%0d required 0/ae07/0", r_status, r_data, mw_cnt); end
      for (int i = 0; i < 8; i++) begin
         a = 16'($urandom); d = 16'($urandom);
         issue(3'd0, a, d, '0);
         ref_mem[int'(a)] = d;
         a = 16'(ref_mem.num() > 1 && i[0] ? 7 : int'(a));
         issue(3'd1, a, 16'($urandom), '0);
         checks++;
         if (r_status !== 2'd0 || r_data !== ref_mem[int'(a)] || r_count !== '0 || ovl != 0) begin
            errors++; $display("FAIL rmem_rand addr=%h status=%0d data=%h required 0/%h", a, r_status, r_data, ref_mem[int'(a)]);
         end
      end
      md_err = 16'h0100;
      issue(3'd0, 16'd20, 16'h5A5A, '0);
      md_err = '0;
      checks++;
      if (r_status !== 2'd3 || r_data !== 16'h5B5A) begin errors++; $display("FAIL wmem_verify status=%0d data=%h required 3/5b5a", r_status, r_data); end
   endtask

   task automatic test_reg();
      logic [RW-1:0] a;
      logic [DW-1:0] d;
      issue(3'd2, 16'd0, 16'd2310, '0);
      checks++;
      if (r_status !== 2'd0 || r_data !== 16'd2310 || mw_cnt != 0) begin errors++; $display("FAIL wreg0 status=%0d data=%h required 0/0906", r_status, r_data); end
      ref_rf[0] = 16'd2310;
      issue(3'd3, 16'd0, 16'h0000, '0);
      checks++;
      if (r_status !== 2'd0 || r_data !== 16'h0906 || lat != AL + 1) begin errors++; $display("FAIL rreg0 status=%0d data=%h latency=%0d required 0/0906/%0d", r_status, r_data, lat, AL + 1); end
      for (int i = 0; i < 6; i++) begin
         a = 4'($urandom); d = 16'($urandom);
         issue(3'd2, {12'($urandom), a}, d, '0);
         ref_rf[int'(a)] = d;
         issue(3'd3, 16'(a), 16'hFFFF, '0);
         checks++;
         if (r_status !== 2'd0 || r_data !== ref_rf[int'(a)] || ovl != 0) begin
            errors++; $display("FAIL rreg_rand addr=%0d status=%0d data=%h required 0/%h", a, r_status, r_data, ref_rf[int'(a)]);
         end
      end
      rd_err = 16'h0001;
      issue(3'd2, 16'd5, 16'h1234, '0);
      rd_err = '0;
      checks++;
      if (r_status !== 2'd3 || r_data !== 16'h1235) begin errors++; $display("FAIL wreg_verify status=%0d data=%h required 3/1235", r_status, r_data); end
   endtask

   task automatic do_run(input string name, input bit is_n, input int start, input int sd, input int tmo, input int g);
      int st, data, cnt, cyc;
      gap = g;
      run_ref(is_n, start, sd, tmo, g + 2, st, data, cnt, cyc);
      issue(is_n ? 3'd5 : 3'd4, 16'(start), 16'(sd), 24'(tmo));
      checks++;
      if (r_status !== 2'(st) || r_data !== 16'(data) || r_count !== 6'(cnt) || tst_cnt != cyc || dbg_test !== 1'b0) begin
         errors++;
         $display("FAIL %s start=%0d arg=%0d tmo=%0d gap=%0d got status=%0d pc=%0d count=%0d run_cycles=%0d required %0d/%0d/%0d/%0d",
                  name, start, sd, tmo, g, r_status, r_data, r_count, tst_cnt, st, data, cnt, cyc);
      end
   endtask

   task automatic test_run_n();
      do_run("run_n5", 1'b1, 0, 5, 0, 0);
      do_run("run_n0", 1'b1, 0, 0, 0, 1);
      do_run("run_n_tie_ok", 1'b1, 3, 3, 6, 0);
      do_run("run_n_tmo", 1'b1, 3, 3, 5, 0);
      for (int i = 0; i < 5; i++)
         do_run("run_n_rand", 1'b1, int'($urandom_range(0, 200)), int'($urandom_range(0, 20)),
                ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 60)) : 0, int'($urandom_range(0, 2)));
   endtask

   task automatic test_run_until();
      int s;
      do_run("until_stop3", 1'b0, 0, 3, 0, 1);
      do_run("until_unreachable", 1'b0, 10, 5, 1000, 0);
      do_run("until_saturate", 1'b0, 0, 69, 0, 0);
      for (int i = 0; i < 5; i++) begin
         s = int'($urandom_range(0, 200));
         do_run("until_rand", 1'b0, s, s + int'($urandom_range(0, 15)),
                ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 50)) : 0, int'($urandom_range(0, 2)));
      end
   endtask

   task automatic test_backpressure();
      logic [1:0]    s0;
      logic [DW-1:0] d0;
      int            bad;
      issue(3'd6, 16'd1, 16'd1, '0);
      checks++;
      if (r_status !== 2'd2 || lat != 1) begin errors++; $display("FAIL bad_cmd6 status=%0d latency=%0d required 2/1", r_status, lat); end
      cmd_valid = 1'b1; cmd_op = 3'd7;
      @(negedge clk);
      s0 = rsp_status; d0 = rsp_data;
      checks++;
      if (rsp_valid !== 1'b1 || s0 !== 2'd2) begin errors++; $display("FAIL bad_cmd7 rsp_valid=%b status=%0d required 1/2", rsp_valid, s0); end
      cmd_op = 3'd0; cmd_addr = 16'd9; cmd_data = 16'h1234;
      bad = 0;
      repeat (5) begin
         @(negedge clk);
         if (rsp_valid !== 1'b1 || rsp_status !== s0 || rsp_data !== d0 || cmd_ready !== 1'b0 || dbg_memop !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL resp_hold unstable_cycles=%0d required 0", bad); end
      cmd_valid = 1'b0; rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      checks++;
      if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL resp_release cmd_ready=%b rsp_valid=%b required 1/0", cmd_ready, rsp_valid); end
   endtask

   task automatic test_reset_mid_run();
      int n, seen;
      gap = 0;
      cmd_valid = 1'b1; cmd_op = 3'd5; cmd_addr = 16'd0; cmd_data = 16'd40; cmd_tmo = '0;
      @(negedge clk);
      cmd_valid = 1'b0;
      n = 0;
      while (dbg_test !== 1'b1 && n < 10) begin @(negedge clk); n++; end
      checks++;
      if (dbg_test !== 1'b1) begin errors++; $display("FAIL run_start dbg_test=%b required 1", dbg_test); end
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if ({dbg_test, dbg_cpu_reset, dbg_resetpc, dbg_memop, dbg_memwrite, dbg_memaddr, dbg_memwdata, dbg_regop,
           dbg_regwrite, dbg_regaddr, dbg_regwdata, rsp_valid, rsp_status, rsp_data, rsp_count} !== '0 || cmd_ready !== 1'b1) begin
         errors++; $display("FAIL reset_mid_run outputs not zero, dbg_test=%b rsp_valid=%b required 0/0", dbg_test, rsp_valid);
      end
      reset = 1'b1;
      seen = 0;
      repeat (6) begin @(negedge clk); if (rsp_valid !== 1'b0 || dbg_test !== 1'b0) seen++; end
      checks++;
      if (seen != 0) begin errors++; $display("FAIL no_resp_after_abort active_cycles=%0d required 0", seen); end
   endtask

   task automatic test_back_to_back();
      issue(3'd0, 16'd300, 16'hC0DE, '0);
      issue(3'd1, 16'd300, 16'h0000, '0);
      checks++;
      if (r_status !== 2'd0 || r_data !== 16'hC0DE) begin errors++; $display("FAIL back_to_back status=%0d data=%h required 0/c0de", r_status, r_data); end
   endtask

   initial begin
      #2000000;
      $display("FAIL global_watchdog simulation did not finish");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_mem();
      test_reg();
      test_run_n();
      test_run_until();
      test_backpressure();
      test_reset_mid_run();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
